// File: rtl/otp_fetch_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otp_fetch_ctl_pkg
//  Description : Shared definitions for the OTP program-memory fetch
//                controller: FSM state encoding, default code-space size,
//                default access time and the erased-cell read value.
//  Revision    : 1.0  initial release
// ============================================================================
package otp_fetch_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2
  } fetch_state_e;

  // 16 KiB of code plus 128 bytes of redundant rows
  localparam int unsigned OTP_SIZE_DEFAULT = 32'h4080;
  localparam int unsigned T_ACC_DEFAULT    = 3;

  // Value returned for erased cells and for addresses outside the OTP
  localparam logic [7:0] ERASED_BYTE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/otp_acc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : otp_acc_timer
//  Description : OTP access-time counter. Loaded with T_ACC when an access
//                starts, counts down once per cycle and flags the last access
//                cycle, which is when the macro output is sampled.
//  Ports       : i_clk   core clock
//                i_rstz  asynchronous active-low reset
//                i_load  start a new access (load T_ACC)
//                i_clr   abort the running access
//                o_done  high during the final access cycle (single pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module otp_acc_timer #(
  parameter int unsigned T_ACC = 3
) (
  input  logic i_clk,
  input  logic i_rstz,
  input  logic i_load,
  input  logic i_clr,
  output logic o_done
);

  localparam logic [3:0] LOAD_VAL = 4'(T_ACC);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = 4'd0;
    end else if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count value 1 is the last cycle of the access window
  assign o_done = (cnt_q == 4'd1);

endmodule
`default_nettype wire

// File: rtl/otp_fetch_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : otp_fetch_ctl
//  Description : MCU program-memory fetch controller for an OTP macro with a
//                one-entry buffer and next-byte prefetch. Hits are acked in
//                the request cycle; misses take T_ACC+1 cycles.
//  Ports       : i_clk, i_rstz          clock, async active-low reset
//                i_mempsrd/i_mempsaddr  MCU read request / byte address
//                o_mempsack/o_mempsdat  ack pulse / read data
//                i_flush                invalidate the buffer
//                o_otp_re/o_otp_a       OTP read enable / byte address
//                i_otp_q                OTP raw data (inverted sense)
//  Revision    : 1.0  initial release
// ============================================================================
module otp_fetch_ctl
  import otp_fetch_ctl_pkg::*;
#(
  parameter int unsigned OTP_SIZE = OTP_SIZE_DEFAULT,
  parameter int unsigned T_ACC    = T_ACC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rstz,
  input  logic        i_mempsrd,
  input  logic [15:0] i_mempsaddr,
  output logic        o_mempsack,
  output logic [7:0]  o_mempsdat,
  input  logic        i_flush,
  output logic        o_otp_re,
  output logic [14:0] o_otp_a,
  input  logic [7:0]  i_otp_q
);

  // 17-bit compares keep A+1 from wrapping past 'hFFFF
  localparam logic [16:0] SIZE_L = 17'(OTP_SIZE);

  fetch_state_e state_q, state_d;
  logic [15:0]  addr_q, addr_d;     // address of the running/last access
  logic         ack_q, ack_d;       // registered ack (miss / out-of-range)
  logic         pf_q, pf_d;         // demand just served from OTP: prefetch addr_q+1
  logic         disc_q, disc_d;     // flush seen during access: drop buffer update
  logic [7:0]   rdat_q, rdat_d;
  logic         valid_q, valid_d;
  logic [15:0]  tag_q, tag_d;
  logic [7:0]   data_q, data_d;

  logic         tmr_load, tmr_clr, tmr_done;
  logic         hit, new_req, req_oor, req_match;
  logic [15:0]  hit_next, pf_next;
  logic         hit_next_ok, pf_next_ok;

  // In the registered-ack cycle the MCU still holds the request it is being
  // acked for; ignoring it there gives exactly one ack per request.
  assign hit       = i_mempsrd & valid_q & (tag_q == i_mempsaddr) & ~ack_q &
                     (state_q != ST_DEMAND);
  assign new_req   = i_mempsrd & ~ack_q & ~hit & (state_q != ST_DEMAND);
  assign req_oor   = ({1'b0, i_mempsaddr} >= SIZE_L);
  assign req_match = new_req & (i_mempsaddr == addr_q);

  assign hit_next    = i_mempsaddr + 16'd1;
  assign hit_next_ok = (({1'b0, i_mempsaddr} + 17'd1) < SIZE_L);
  assign pf_next     = addr_q + 16'd1;
  assign pf_next_ok  = (({1'b0, addr_q} + 17'd1) < SIZE_L);

  otp_acc_timer #(
    .T_ACC (T_ACC)
  ) u_acc_timer (
    .i_clk  (i_clk),
    .i_rstz (i_rstz),
    .i_load (tmr_load),
    .i_clr  (tmr_clr),
    .o_done (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ack_d    = 1'b0;
    pf_d     = 1'b0;
    disc_d   = disc_q;
    rdat_d   = rdat_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pf_q) begin
          if (pf_next_ok) begin
            state_d  = ST_PREFETCH;
            addr_d   = pf_next;
            tmr_load = 1'b1;
            disc_d   = 1'b0;
          end
        end else if (hit) begin
          if (hit_next_ok) begin
            state_d  = ST_PREFETCH;
            addr_d   = hit_next;
            tmr_load = 1'b1;
            disc_d   = 1'b0;
          end
        end else if (new_req) begin
          if (req_oor) begin
            ack_d  = 1'b1;
            rdat_d = ERASED_BYTE;
          end else begin
            state_d  = ST_DEMAND;
            addr_d   = i_mempsaddr;
            tmr_load = 1'b1;
            disc_d   = 1'b0;
          end
        end
      end

      ST_DEMAND: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          pf_d    = 1'b1;
          rdat_d  = ~i_otp_q;
          if (!disc_q) begin
            valid_d = 1'b1;
            tag_d   = addr_q;
            data_d  = ~i_otp_q;
          end
        end
      end

      ST_PREFETCH: begin
        // Abort when the MCU wants something other than the byte in flight.
        // A hit whose successor is already being prefetched lets it run on.
        if ((new_req && !req_match) ||
            (hit && !(hit_next_ok && (hit_next == addr_q)))) begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
          if (new_req && req_oor) begin
            ack_d  = 1'b1;
            rdat_d = ERASED_BYTE;
          end
        end else if (tmr_done) begin
          state_d = ST_IDLE;
          if (!disc_q) begin
            valid_d = 1'b1;
            tag_d   = addr_q;
            data_d  = ~i_otp_q;
          end
          if (req_match) begin
            ack_d  = 1'b1;
            pf_d   = 1'b1;
            rdat_d = ~i_otp_q;
          end
        end else if (req_match) begin
          // Demand for the byte in flight: keep the access, just ack it
          state_d = ST_DEMAND;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase

    // Flush wins over any buffer fill in the same cycle; an access already
    // in progress must not refill the buffer with pre-flush contents.
    if (i_flush) begin
      valid_d = 1'b0;
      if (state_q != ST_IDLE) begin
        disc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      ack_q   <= 1'b0;
      pf_q    <= 1'b0;
      disc_q  <= 1'b0;
      rdat_q  <= ERASED_BYTE;
      valid_q <= 1'b0;
      tag_q   <= 16'h0000;
      data_q  <= ERASED_BYTE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      pf_q    <= pf_d;
      disc_q  <= disc_d;
      rdat_q  <= rdat_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign o_mempsack = ack_q | hit;
  assign o_mempsdat = hit ? data_q : rdat_q;
  assign o_otp_re   = (state_q != ST_IDLE);
  assign o_otp_a    = addr_q[14:0];

endmodule
`default_nettype wire

// File: tb/tb_otp_fetch_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otp_fetch_ctl
//  Description : Directed self-checking bench for otp_fetch_ctl. An OTP
//                content model drives i_otp_q; every ack is checked against
//                the read-value model and request latencies are hand-derived.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_otp_fetch_ctl;
  import otp_fetch_ctl_pkg::*;

  localparam int unsigned SIZE = 32'h4080;
  localparam int unsigned TACC = 3;

  logic        i_clk       = 1'b0;
  logic        i_rstz      = 1'b0;
  logic        i_mempsrd   = 1'b0;
  logic [15:0] i_mempsaddr = 16'h0000;
  logic        i_flush     = 1'b0;
  logic        o_mempsack;
  logic [7:0]  o_mempsdat;
  logic        o_otp_re;
  logic [14:0] o_otp_a;
  logic [7:0]  i_otp_q;

  int total    = 0;
  int bad      = 0;
  int re_total = 0;

  always #5 i_clk = ~i_clk;

  otp_fetch_ctl #(
    .OTP_SIZE (SIZE),
    .T_ACC    (TACC)
  ) dut (
    .i_clk       (i_clk),
    .i_rstz      (i_rstz),
    .i_mempsrd   (i_mempsrd),
    .i_mempsaddr (i_mempsaddr),
    .o_mempsack  (o_mempsack),
    .o_mempsdat  (o_mempsdat),
    .i_flush     (i_flush),
    .o_otp_re    (o_otp_re),
    .o_otp_a     (o_otp_a),
    .i_otp_q     (i_otp_q)
  );

  // Raw OTP contents: 'h0000 holds 'h3C, 'h0050 is erased, rest a pattern
  function automatic logic [7:0] otp_raw(input logic [14:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    if (a == 15'h0050) return 8'h00;
    lo = a[7:0];
    hi = {1'b0, a[14:8]};
    return lo + hi * 8'd3 + 8'h3C;
  endfunction

  // What a read of byte address a must return
  function automatic logic [7:0] exp_read(input logic [15:0] a);
    if ({16'h0000, a} >= SIZE) return ERASED_BYTE;
    return ~otp_raw(a[14:0]);
  endfunction

  assign i_otp_q = otp_raw(o_otp_a);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Per-cycle checks of everything observable at the pins
  initial begin
    logic        prev_re   = 1'b0;
    logic [14:0] prev_a    = 15'h0;
    logic        prev_ack  = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    forever begin
      @(negedge i_clk);
      if (!i_rstz) begin
        prev_re  = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (o_mempsack) begin
          chk("ack_while_rd", 32'(i_mempsrd), 32'd1);
          chk($sformatf("ack_data_%h", i_mempsaddr), 32'(o_mempsdat), 32'(exp_read(i_mempsaddr)));
          chk("single_ack", 32'(prev_ack && (prev_addr == i_mempsaddr)), 32'd0);
        end
        if (o_otp_re) begin
          re_total++;
          chk("re_range", 32'({17'h0, o_otp_a} < SIZE), 32'd1);
          if (prev_re) chk("re_addr_stable", 32'(o_otp_a), 32'(prev_a));
        end
        prev_re   = o_otp_re;
        prev_a    = o_otp_a;
        prev_ack  = o_mempsack;
        prev_addr = i_mempsaddr;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
  endtask

  // Issue one read, measure cycles to ack; keep=1 leaves rd high for a
  // back-to-back follow-up in the next cycle.
  task automatic do_read(input logic [15:0] a, input int exp_lat, input bit keep,
                         output int lat, output logic [7:0] dat);
    bit got;
    got = 1'b0;
    @(posedge i_clk); #1;
    i_mempsrd   = 1'b1;
    i_mempsaddr = a;
    lat = 0;
    dat = 8'h00;
    while (!got && lat < 40) begin
      @(negedge i_clk);
      if (o_mempsack) begin
        got = 1'b1;
        dat = o_mempsdat;
      end else begin
        @(posedge i_clk); #1;
        lat++;
      end
    end
    chk($sformatf("ack_seen_%h", a), 32'(got), 32'd1);
    if (got) chk($sformatf("latency_%h", a), 32'(lat), 32'(exp_lat));
    if (!keep || !got) begin
      @(posedge i_clk); #1;
      i_mempsrd = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] dat;
    int         snap;
    int         hits;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ack", 32'(o_mempsack), 32'd0);
    chk("rst_dat", 32'(o_mempsdat), 32'hFF);
    chk("rst_re",  32'(o_otp_re),   32'd0);
    chk("rst_a",   32'(o_otp_a),    32'd0);
    @(posedge i_clk); #1;
    i_rstz = 1'b1;

    // First read from reset: miss, 3 access cycles, inverted data
    snap = re_total;
    do_read(16'h0000, 4, 1'b0, lat, dat);
    chk("first_read_data", 32'(dat), 32'hC3);
    chk("first_read_re_cycles", 32'(re_total - snap), 32'd3);

    // Erased cell reads as 'hFF
    idle(6);
    do_read(16'h0050, 4, 1'b0, lat, dat);
    chk("erased_data", 32'(dat), 32'hFF);

    // Sequential reads: one miss then seven prefetch hits
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      idle(6);
      do_read(16'h0100 + 16'(i), (i == 0) ? 4 : 0, 1'b0, lat, dat);
      if (lat == 0) hits++;
    end
    chk("seq_hits", 32'(hits), 32'd7);

    // Different demand during prefetch aborts it; new byte then hits
    idle(6);
    do_read(16'h0200, 4, 1'b0, lat, dat);
    do_read(16'h0800, 5, 1'b0, lat, dat);
    do_read(16'h0800, 0, 1'b0, lat, dat);

    // Back-to-back sequential requests ride the in-flight prefetch
    idle(6);
    do_read(16'h0300, 4, 1'b1, lat, dat);
    do_read(16'h0301, 3, 1'b1, lat, dat);
    do_read(16'h0302, 3, 1'b0, lat, dat);

    // Top of the OTP: no prefetch past the end, out-of-range acks with FF
    idle(6);
    do_read(16'h407F, 4, 1'b0, lat, dat);
    snap = re_total;
    idle(6);
    chk("no_prefetch_at_top", 32'(re_total - snap), 32'd0);
    do_read(16'h4080, 1, 1'b0, lat, dat);
    chk("oor_data", 32'(dat), 32'hFF);
    do_read(16'hFFFF, 1, 1'b0, lat, dat);
    chk("oor_no_access", 32'(re_total - snap), 32'd0);

    // Hit, flush, re-read misses
    idle(6);
    do_read(16'h000F, 4, 1'b0, lat, dat);
    idle(6);
    do_read(16'h0010, 0, 1'b0, lat, dat);
    idle(6);
    @(posedge i_clk); #1; i_flush = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0;
    idle(2);
    do_read(16'h0010, 4, 1'b0, lat, dat);

    // Flush during a prefetch discards its buffer fill
    idle(6);
    do_read(16'h0610, 4, 1'b0, lat, dat);
    @(posedge i_clk); #1; i_flush = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0;
    idle(4);
    do_read(16'h0611, 4, 1'b0, lat, dat);

    // Flush during a demand still returns its data; later prefetch is kept
    idle(6);
    fork
      do_read(16'h0620, 4, 1'b0, lat, dat);
      begin
        @(posedge i_clk);
        @(posedge i_clk); #1; i_flush = 1'b1;
        @(posedge i_clk); #1; i_flush = 1'b0;
      end
    join
    chk("flush_demand_data", 32'(dat), 32'(exp_read(16'h0620)));
    idle(6);
    do_read(16'h0621, 0, 1'b0, lat, dat);

    // Reset in the middle of an access
    idle(6);
    @(posedge i_clk); #1;
    i_mempsaddr = 16'h0900;
    i_mempsrd   = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk); #1;
    chk("rst_mid_re_before", 32'(o_otp_re), 32'd1);
    i_rstz = 1'b0;
    #1;
    chk("rst_mid_re",  32'(o_otp_re),   32'd0);
    chk("rst_mid_ack", 32'(o_mempsack), 32'd0);
    @(posedge i_clk); #1; i_mempsrd = 1'b0;
    @(posedge i_clk); #1; i_rstz = 1'b1;
    idle(6);
    do_read(16'h0900, 4, 1'b0, lat, dat);

    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/otp_fetch_ctl.md
OTP_FETCH_CTL -- requirements
Module: otp_fetch_ctl

Interface
REQ-001 Parameter OTP_SIZE, default 'h4080, code space size in bytes (16K + 128B redundant).
REQ-002 Parameter T_ACC, default 3, OTP macro read access time in i_clk cycles (range 1..15).
REQ-003 i_clk  input  1  core clock; all state on rising edge.
REQ-004 i_rstz  input  1  reset, asynchronous, active-low.
REQ-005 i_mempsrd  input  1  MCU program-memory read request, level, held until acknowledged.
REQ-006 i_mempsaddr  input  16  MCU program-memory byte address, stable while i_mempsrd high.
REQ-007 o_mempsack  output  1  read acknowledge, one-cycle pulse per served request.
REQ-008 o_mempsdat  output  8  read data, valid in the cycle o_mempsack is high.
REQ-009 i_flush  input  1  invalidates the prefetch buffer (asserted after OTP programming).
REQ-010 o_otp_re  output  1  OTP macro read enable, held high for T_ACC cycles per access.
REQ-011 o_otp_a  output  15  OTP byte address, stable while o_otp_re high.
REQ-012 i_otp_q  input  8  OTP raw cell data (programmed cells read inverted), sampled on last access cycle.

Function
REQ-013 Returned data SHALL be ~i_otp_q; erased OTP (raw 'h00) reads as 'hFF.
REQ-014 Addresses >= OTP_SIZE SHALL ack next cycle with 'hFF and no OTP access.
REQ-015 One-entry buffer {valid, tag[15:0], data[7:0]} holds the last byte fetched (demand or prefetch).
REQ-016 Hit (i_mempsrd, valid, tag==i_mempsaddr): o_mempsack high in the same cycle, o_mempsdat = buffer data, zero wait.
REQ-017 Miss: OTP access at i_mempsaddr starts next cycle; ack in the cycle after the T_ACC-th access cycle (miss latency T_ACC+1); buffer updated with that byte.
REQ-018 After every served demand at address A (hit or miss), if A+1 < OTP_SIZE, a prefetch of A+1 SHALL start next cycle; address arithmetic 16-bit, no wrap beyond OTP_SIZE-1.
REQ-019 FSM states: IDLE, DEMAND, PREFETCH; IDLE->DEMAND on miss; IDLE->PREFETCH after served demand; DEMAND->IDLE on ack; PREFETCH->IDLE on completion (buffer filled, valid=1).
REQ-020 Demand arriving during PREFETCH with address == prefetch address: PREFETCH converts to DEMAND, ack on prefetch completion (no restart).
REQ-021 Demand during PREFETCH with different address: prefetch aborted that cycle, o_otp_re low for at least one cycle, DEMAND starts following cycle; buffer not updated by aborted access.
REQ-022 i_flush clears valid in the next cycle; flush during an access discards that access's buffer update but a DEMAND still acks with its fetched data.
REQ-023 At most one ack per i_mempsrd assertion per address; back-to-back requests (i_mempsrd high, new address next cycle) are each served.
REQ-024 o_otp_re SHALL never be asserted for an address >= OTP_SIZE.

Reset
REQ-025 On i_rstz low: FSM IDLE, valid=0, tag='h0000, data='hFF, o_mempsack=0, o_mempsdat='hFF, o_otp_re=0, o_otp_a=0, access counter 0.
REQ-026 Reset asserted mid-access SHALL abort immediately; first request after release is a miss.

Structure
REQ-027 FSM state encoding and OTP_SIZE/erased-value constants reside in the shared core package.
REQ-028 Access-time counter is one sub-module, otp_acc_timer (load T_ACC, count down, done pulse).

Verification
REQ-029 T_ACC=3, raw OTP 'h0000='h3C; read 'h0000 from reset -> ack at cycle 4, data 'hC3; o_otp_re high 3 cycles.
REQ-030 Sequential reads 'h0100..'h0107 spaced >= 5 cycles -> first miss, remaining 7 zero-wait hits; hit rate 87%.
REQ-031 Read 'h0200, then 'h0800 two cycles later -> prefetch of 'h0201 aborted, 'h0800 acked 5 cycles after request, buffer tag 'h0800.
REQ-032 Read 'h407F then 'h4080 -> 'h407F from OTP, no prefetch, 'h4080 acked next cycle with 'hFF, o_otp_re never high.
REQ-033 Hit on 'h0010, assert i_flush, re-read 'h0010 -> second read is a miss (latency 4).
REQ-034 i_rstz low during access cycle 2 -> o_otp_re and o_mempsack low immediately, no spurious ack after release.
